// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_WORD_SIZE = 8;
  localparam int STAT_W         = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: searches upward from last+1 with wrap,
// so the most recent winner has the lowest priority.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest set bit overwrites.
  always_comb begin
    winner = last;
    any    = |req;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[(int'(last) + off) % NUM_REQ]) begin
        winner = IDX_W'((int'(last) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional per-requester grant counters are built when UART_ARB_STATS_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WORD_SIZE    = UART_WORD_SIZE,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [WORD_SIZE-1:0]           tx_data,
  output logic                           tx_start,
  input  logic                           tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           tx_err
`ifdef UART_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]      grant_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  // Handshake: a word is accepted on the single cycle req_ready[i] is high;
  // tx_start rises in that same cycle and the transmitter answers with tx_busy.
  arb_state_t             state, state_next;
  logic [IDX_W-1:0]       winner, grant_next;
  logic                   any_req;
  logic [WORD_SIZE-1:0]   data_next;
  logic [NUM_REQ-1:0]     ready_next;
  logic                   start_next;
  logic                   err_next;
  logic [CNT_W-1:0]       busy_cnt, busy_cnt_next;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req_valid),
    .last   (grant_id),
    .winner (winner),
    .any    (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= IDX_W'(NUM_REQ - 1);
      tx_data   <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_err    <= 1'b0;
      busy_cnt  <= '0;
    end else begin
      state     <= state_next;
      grant_id  <= grant_next;
      tx_data   <= data_next;
      req_ready <= ready_next;
      tx_start  <= start_next;
      tx_err    <= err_next;
      busy_cnt  <= busy_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    grant_next    = grant_id;
    data_next     = tx_data;
    ready_next    = '0;
    start_next    = 1'b0;
    err_next      = tx_err;
    busy_cnt_next = busy_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_next    = winner;
          data_next     = req_data[winner*WORD_SIZE +: WORD_SIZE];
          ready_next    = NUM_REQ'(1) << winner;
          start_next    = 1'b1;
          busy_cnt_next = '0;
          state_next    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A launch that never raises tx_busy still counts as consumed.
        if (tx_busy) begin
          busy_cnt_next = '0;
          state_next    = WAIT_DONE;
        end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          err_next      = 1'b1;
          busy_cnt_next = '0;
          state_next    = IDLE;
        end else begin
          busy_cnt_next = busy_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        stat_q[i] <= '0;
      end else if (req_ready[i] && (stat_q[i] != {STAT_W{1'b1}})) begin
        stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign grant_count[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (4 requesters, 8-bit words, timeout 64).
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int EW = 2 + W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           tx_err;
`ifdef UART_ARB_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .BUSY_TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .tx_err    (tx_err)
`ifdef UART_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // transmitter model: busy for busy_len cycles after each tx_start
  int  checks = 0;
  int  errors = 0;
  int  start_cnt = 0;
  bit  xmit_en = 1'b1;
  int  busy_len = 6;
  int  busy_left = 0;

  always @(posedge clk) begin
    if (tx_start && xmit_en) begin
      tx_busy   <= 1'b1;
      busy_left <= busy_len;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) tx_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard: {grant, word} pushed by drivers, popped on each tx_start
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_exp;

  always @(negedge clk) begin
    if (!rst && tx_start) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        m_exp = exp_q.pop_front();
        check("grant_id", 32'(grant_id), 32'(m_exp[EW-1:W]));
        check("tx_data", 32'(tx_data), 32'(m_exp[W-1:0]));
        check("req_ready", 32'(req_ready), 32'(1) << m_exp[EW-1:W]);
      end
    end else if (!rst && req_ready != '0) begin
      check("ready_without_start", 32'(req_ready), 32'd0);
    end
  end

  // driver tasks
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dut.state == IDLE) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_words(input logic [W-1:0] win_word, input logic [1:0] g);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom_range(0, 255));
    req_data[g*W +: W] = win_word;
  endtask

  task automatic apply(input logic [N-1:0] v, input logic [W-1:0] word, input logic [1:0] g);
    bit ok;
    load_words(word, g);
    exp_q.push_back({g, word});
    req_valid = v;
    wait_start(ok);
    if (ok) begin
      @(negedge clk);
      check("start_one_cycle", 32'(tx_start), 32'd0);
      check("ready_one_cycle", 32'(req_ready), 32'd0);
    end
    req_valid = '0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [W-1:0] word;
    logic [1:0]   grant;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit ok;
    int base;
    logic [W-1:0] fw [N];

    vecs[0] = '{4'b0100, 8'hA5, 2'd2};
    vecs[1] = '{4'b1111, 8'h3C, 2'd3};
    vecs[2] = '{4'b1001, 8'h00, 2'd0};
    vecs[3] = '{4'b1001, 8'hFF, 2'd3};
    vecs[4] = '{4'b0010, 8'h5A, 2'd1};
    vecs[5] = '{4'b0011, 8'h81, 2'd0};
    vecs[6] = '{4'b0001, 8'h7E, 2'd0};
    vecs[7] = '{4'b1100, 8'hC3, 2'd2};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_grant_id", 32'(grant_id), 32'd3);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_err", 32'(tx_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven grants, including wrap-around 3 -> 0 -> 3
    for (int i = 0; i < 8; i++) apply(vecs[i].valid, vecs[i].word, vecs[i].grant);
    check("tx_data_held", 32'(tx_data), 32'hC3);

    // timeout with a silent transmitter
    xmit_en = 1'b0;
    load_words(8'h11, 2'd1);
    exp_q.push_back({2'd1, 8'h11});
    req_valid = 4'b0010;
    wait_start(ok);
    req_valid = '0;
    repeat (63) @(negedge clk);
    check("tx_err_before_timeout", 32'(tx_err), 32'd0);
    check("state_before_timeout", 32'(dut.state), 32'(WAIT_BUSY));
    @(negedge clk);
    check("tx_err_at_timeout", 32'(tx_err), 32'd1);
    check("state_after_timeout", 32'(dut.state), 32'(IDLE));
    xmit_en = 1'b1;
    apply(4'b0001, 8'h22, 2'd0);
    check("tx_err_sticky", 32'(tx_err), 32'd1);

    // requester raises and withdraws while the transfer is in flight
    busy_len = 20;
    base = start_cnt;
    load_words(8'h33, 2'd2);
    exp_q.push_back({2'd2, 8'h33});
    req_valid = 4'b0100;
    wait_start(ok);
    req_valid = '0;
    repeat (5) @(negedge clk);
    req_valid = 4'b1000;
    repeat (3) @(negedge clk);
    req_valid = '0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("withdraw_no_start", 32'(start_cnt - base), 32'd1);

    // reset while waiting for the transmitter to finish
    busy_len = 40;
    load_words(8'h44, 2'd3);
    exp_q.push_back({2'd3, 8'h44});
    req_valid = 4'b1000;
    wait_start(ok);
    req_valid = '0;
    repeat (5) @(negedge clk);
    check("state_wait_done", 32'(dut.state), 32'(WAIT_DONE));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_grant_id", 32'(grant_id), 32'd3);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_tx_err", 32'(tx_err), 32'd0);
    rst = 1'b0;
    base = start_cnt;
    repeat (60) @(negedge clk);
    check("mid_rst_no_start", 32'(start_cnt - base), 32'd0);
    apply(4'b0110, 8'h55, 2'd1);

    // fairness: all four held, 40-cycle transfers
    do_reset();
    for (int i = 0; i < N; i++) begin
      fw[i] = W'($urandom_range(0, 255));
      req_data[i*W +: W] = fw[i];
    end
    for (int k = 0; k < 5; k++) exp_q.push_back({2'(k % N), fw[k % N]});
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) wait_start(ok);
    req_valid = '0;
    wait_idle();
    check("fair_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef UART_ARB_STATS_EN
    busy_len = 4;
    do_reset();
    for (int k = 0; k < 3; k++) apply(4'b0010, 8'(8'h60 + k), 2'd1);
    @(negedge clk);
    check("stat_req0", 32'(grant_count[15:0]), 32'd0);
    check("stat_req1", 32'(grant_count[31:16]), 32'd3);
    check("stat_req2", 32'(grant_count[47:32]), 32'd0);
    check("stat_req3", 32'(grant_count[63:48]), 32'd0);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
